// File: rtl/iu_chk.sv
// iu_chk: prediction checker closing the iu feedback loop.
// Queues iu predictions, compares them in order against committed PCs,
// reseeds iu on mismatch/overflow/reset and counts hits and misses.
module iu_chk #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      pc_pre,
  input  logic             pc_pre_oe,
  input  logic             commit_valid,
  output logic             commit_ready,
  input  logic [63:0]      commit_pc,
  input  logic [31:0]      commit_insn,
  output logic             miss,
  output logic [63:0]      pc_curr,
  output logic [31:0]      insn_curr,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    FLUSH  = 2'd1,
    RESEED = 2'd2,
    RUN    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [63:0]        mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        cnt_q, cnt_d;
  logic               miss_q, miss_d;
  logic [63:0]        pc_curr_q, pc_curr_d;
  logic [31:0]        insn_curr_q, insn_curr_d;
  logic [63:0]        last_q, last_d;
  logic [CNT_W-1:0]   hit_q, hit_d;
  logic [CNT_W-1:0]   mcnt_q, mcnt_d;
  logic               ovf_q, ovf_d;
  logic               push_en;
  logic               xfer;
  logic               fifo_full;
  logic [63:0]        head;

  assign fifo_full = (cnt_q == FULL_CNT);
  assign head      = mem_q[rd_ptr_q];
  assign xfer      = commit_valid && commit_ready;

  // Commit acceptance: any commit while seeding, otherwise only with a queued prediction.
  always_comb begin
    commit_ready = 1'b0;
    if (!rst) begin
      unique case (state_q)
        SEED:    commit_ready = 1'b1;
        RUN:     commit_ready = (cnt_q != '0);
        default: commit_ready = 1'b0;
      endcase
    end
  end

  // Next-state, FIFO control and counter updates.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    miss_d      = miss_q;
    pc_curr_d   = pc_curr_q;
    insn_curr_d = insn_curr_q;
    last_d      = last_q;
    hit_d       = hit_q;
    mcnt_d      = mcnt_q;
    ovf_d       = ovf_q;
    push_en     = 1'b0;

    unique case (state_q)
      SEED: begin
        if (xfer) begin
          pc_curr_d   = commit_pc;
          insn_curr_d = commit_insn;
          last_d      = commit_pc;
          miss_d      = 1'b1;
          state_d     = FLUSH;
        end
      end

      FLUSH: begin
        if (pc_pre_oe) state_d = RESEED;
      end

      RESEED: begin
        miss_d  = 1'b0;
        state_d = RUN;
      end

      RUN: begin
        if (xfer && (head != commit_pc)) begin
          // Mismatch flushes the queue, so a same-cycle push is dropped.
          mcnt_d      = mcnt_q + CNT_W'(1);
          last_d      = commit_pc;
          pc_curr_d   = commit_pc;
          insn_curr_d = commit_insn;
          miss_d      = 1'b1;
          wr_ptr_d    = '0;
          rd_ptr_d    = '0;
          cnt_d       = '0;
          state_d     = FLUSH;
        end else if (pc_pre_oe && fifo_full && !xfer) begin
          ovf_d     = 1'b1;
          pc_curr_d = last_q;
          miss_d    = 1'b1;
          wr_ptr_d  = '0;
          rd_ptr_d  = '0;
          cnt_d     = '0;
          state_d   = FLUSH;
        end else begin
          if (xfer) begin
            hit_d    = hit_q + CNT_W'(1);
            last_d   = commit_pc;
            rd_ptr_d = rd_ptr_q + AW'(1);
          end
          if (pc_pre_oe) begin
            push_en  = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
          end
          if (push_en && !xfer)      cnt_d = cnt_q + (AW+1)'(1);
          else if (!push_en && xfer) cnt_d = cnt_q - (AW+1)'(1);
        end
      end

      default: state_d = SEED;
    endcase
  end

  // State and control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SEED;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      miss_q      <= 1'b0;
      pc_curr_q   <= '0;
      insn_curr_q <= '0;
      last_q      <= '0;
      hit_q       <= '0;
      mcnt_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      miss_q      <= miss_d;
      pc_curr_q   <= pc_curr_d;
      insn_curr_q <= insn_curr_d;
      last_q      <= last_d;
      hit_q       <= hit_d;
      mcnt_q      <= mcnt_d;
      ovf_q       <= ovf_d;
    end
  end

  // Prediction storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= pc_pre;
  end

  assign miss      = miss_q;
  assign pc_curr   = pc_curr_q;
  assign insn_curr = insn_curr_q;
  assign hit_cnt   = hit_q;
  assign miss_cnt  = mcnt_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_iu_chk.sv
// Self-checking bench for iu_chk: directed scenarios followed by random
// traffic, all checked against a queue-based behavioural model.
module tb_iu_chk;

  localparam int DEPTH = 4;
  localparam int CNT_W = 32;

  logic             clk;
  logic             rst;
  logic [63:0]      pc_pre;
  logic             pc_pre_oe;
  logic             commit_valid;
  logic             commit_ready;
  logic [63:0]      commit_pc;
  logic [31:0]      commit_insn;
  logic             miss;
  logic [63:0]      pc_curr;
  logic [31:0]      insn_curr;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;
  logic             overflow;

  iu_chk #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_pre       (pc_pre),
    .pc_pre_oe    (pc_pre_oe),
    .commit_valid (commit_valid),
    .commit_ready (commit_ready),
    .commit_pc    (commit_pc),
    .commit_insn  (commit_insn),
    .miss         (miss),
    .pc_curr      (pc_curr),
    .insn_curr    (insn_curr),
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Behavioural model: mode plus a plain queue of outstanding predictions.
  typedef enum {M_SEED, M_FLUSH, M_RESEED, M_RUN} mode_t;
  mode_t       m_mode;
  logic [63:0] m_q[$];
  logic        m_miss, m_ovf, m_xfer;
  logic [63:0] m_pc_curr, m_last;
  logic [31:0] m_insn;
  logic [31:0] m_hit, m_mcnt;

  task automatic model_reset();
    m_mode = M_SEED;
    m_q.delete();
    m_miss = 1'b0; m_ovf = 1'b0; m_xfer = 1'b0;
    m_pc_curr = '0; m_last = '0; m_insn = '0;
    m_hit = '0; m_mcnt = '0;
  endtask

  function automatic logic m_ready();
    if (rst) return 1'b0;
    return (m_mode == M_SEED) || (m_mode == M_RUN && m_q.size() > 0);
  endfunction

  task automatic model_clock(input logic pv, input logic [63:0] pp, input logic cv,
                             input logic [63:0] cpc, input logic [31:0] ci);
    logic [63:0] h;
    m_xfer = cv && m_ready();
    case (m_mode)
      M_SEED: if (m_xfer) begin
        m_pc_curr = cpc; m_insn = ci; m_last = cpc; m_miss = 1'b1; m_mode = M_FLUSH;
      end
      M_FLUSH: if (pv) m_mode = M_RESEED;
      M_RESEED: begin m_miss = 1'b0; m_mode = M_RUN; end
      M_RUN: begin
        if (m_xfer) begin
          h = m_q.pop_front();
          m_last = cpc;
          if (h == cpc) begin
            m_hit++;
            if (pv) m_q.push_back(pp);
          end else begin
            m_mcnt++;
            m_q.delete();
            m_pc_curr = cpc; m_insn = ci; m_miss = 1'b1; m_mode = M_FLUSH;
          end
        end else if (pv) begin
          if (m_q.size() == DEPTH) begin
            m_ovf = 1'b1; m_q.delete();
            m_pc_curr = m_last; m_miss = 1'b1; m_mode = M_FLUSH;
          end else begin
            m_q.push_back(pp);
          end
        end
      end
      default: m_mode = M_SEED;
    endcase
  endtask

  task automatic check_outputs();
    check_eq("miss",      64'(miss),      64'(m_miss));
    check_eq("pc_curr",   pc_curr,        m_pc_curr);
    check_eq("insn_curr", 64'(insn_curr), 64'(m_insn));
    check_eq("hit_cnt",   64'(hit_cnt),   64'(m_hit));
    check_eq("miss_cnt",  64'(miss_cnt),  64'(m_mcnt));
    check_eq("overflow",  64'(overflow),  64'(m_ovf));
  endtask

  // One clock cycle: called at posedge+1, drives inputs, checks ready, then registered outputs.
  task automatic step(input logic pv, input logic [63:0] pp, input logic cv,
                      input logic [63:0] cpc, input logic [31:0] ci);
    pc_pre_oe = pv; pc_pre = pp; commit_valid = cv; commit_pc = cpc; commit_insn = ci;
    #2;
    check_eq("commit_ready", 64'(commit_ready), 64'(m_ready()));
    model_clock(pv, pp, cv, cpc, ci);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // Asynchronous reset pulse between clock edges; called at posedge+1.
  task automatic pulse_reset();
    pc_pre_oe = 1'b0; commit_valid = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    check_eq("ready_in_rst", 64'(commit_ready), 64'(m_ready()));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic        rv;
  logic [63:0] rpc;
  logic [31:0] rins;
  logic [63:0] iu_pc;
  logic        pv;
  logic [63:0] pp;

  initial begin
    rst = 1'b1; pc_pre = '0; pc_pre_oe = 1'b0;
    commit_valid = 1'b0; commit_pc = '0; commit_insn = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outputs();
    check_eq("ready_in_rst", 64'(commit_ready), 64'(m_ready()));
    rst = 1'b0;

    // Seed at 0x1000, stale prediction discarded, then three hits.
    step(1'b0, 64'h0, 1'b1, 64'h1000, 32'h0000_0013);
    check_eq("s1_pc_curr", pc_curr, 64'h1000);
    step(1'b1, 64'h1004, 1'b0, 64'h0, 32'h0);
    step(1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
    step(1'b1, 64'h1004, 1'b0, 64'h0, 32'h0);
    step(1'b1, 64'h1008, 1'b1, 64'h1004, 32'h1);
    step(1'b1, 64'h100C, 1'b1, 64'h1008, 32'h2);
    step(1'b1, 64'h1010, 1'b1, 64'h100C, 32'h3);
    check_eq("s1_hit", 64'(hit_cnt), 64'd3);
    check_eq("s1_miss", 64'(miss), 64'd0);

    // Mispredict: head 0x1010 vs commit 0x2000.
    step(1'b0, 64'h0, 1'b1, 64'h2000, 32'hABCD_0001);
    check_eq("s2_mcnt", 64'(miss_cnt), 64'd1);
    check_eq("s2_pc_curr", pc_curr, 64'h2000);
    step(1'b1, 64'h2004, 1'b0, 64'h0, 32'h0);
    step(1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
    step(1'b1, 64'h2004, 1'b0, 64'h0, 32'h0);
    step(1'b0, 64'h0, 1'b1, 64'h2004, 32'h5);
    check_eq("s2_hit", 64'(hit_cnt), 64'd4);

    // Overflow: five predictions with no commits.
    for (int i = 0; i < 5; i++) step(1'b1, 64'h2008 + 64'(4 * i), 1'b0, 64'h0, 32'h0);
    check_eq("s3_ovf", 64'(overflow), 64'd1);
    check_eq("s3_pc_curr", pc_curr, 64'h2004);
    check_eq("s3_mcnt", 64'(miss_cnt), 64'd1);

    // Reset while in FLUSH.
    pulse_reset();

    // Refill, then full FIFO with simultaneous push and matching pop.
    step(1'b0, 64'h0, 1'b1, 64'h3000, 32'h7);
    step(1'b1, 64'h3004, 1'b0, 64'h0, 32'h0);
    step(1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 64'h3004 + 64'(4 * i), 1'b0, 64'h0, 32'h0);
    step(1'b1, 64'h3014, 1'b1, 64'h3004, 32'h8);
    check_eq("s4_hit", 64'(hit_cnt), 64'd1);
    check_eq("s4_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 64'h0, 1'b1, 64'h3008 + 64'(4 * i), 32'h9);

    // commit_valid held against an empty FIFO.
    for (int i = 0; i < 3; i++) step(1'b0, 64'h0, 1'b1, 64'h3018, 32'hA);
    step(1'b1, 64'h3018, 1'b1, 64'h3018, 32'hA);
    step(1'b0, 64'h0, 1'b1, 64'h3018, 32'hA);
    check_eq("s5_hit", 64'(hit_cnt), 64'd6);
    step(1'b0, 64'h0, 1'b0, 64'h0, 32'h0);

    // Random traffic.
    rv = 1'b0; rpc = '0; rins = '0; iu_pc = 64'h4000;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        pulse_reset();
        rv = 1'b0;
      end else begin
        if (!rv && $urandom_range(0, 9) < 6) begin
          rv = 1'b1;
          rins = $urandom;
          if (m_q.size() > 0 && $urandom_range(0, 99) < 85) rpc = m_q[0];
          else rpc = {32'h0, $urandom} & ~64'h3;
        end
        pv = ($urandom_range(0, 9) < 4);
        if (pv) iu_pc = iu_pc + 64'h4;
        pp = ($urandom_range(0, 19) == 0) ? {$urandom, $urandom} : iu_pc;
        step(pv, pp, rv, rpc, rins);
        if (m_xfer) rv = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/iu_chk.md
Name: iu_chk

Overview:
- Prediction checker that sits directly downstream of the `iu` PC-prediction stage and closes its feedback loop.
- Queues each `pc_pre` the `iu` emits and compares it, in order, against the actual committed-PC stream from the simulator interface.
- On a mismatch, or after reset, it drives `miss`/`pc_curr`/`insn_curr` back into the `iu` to reseed it, and counts hits and misses.

Parameters:
- DEPTH, 4: prediction FIFO entries; power of 2, minimum 2.
- CNT_W, 32: width of `hit_cnt` and `miss_cnt`.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- pc_pre  input  64  predicted next PC from `iu`.
- pc_pre_oe  input  1  single-cycle strobe; `pc_pre` is valid this cycle.
- commit_valid  input  1  committed instruction available.
- commit_ready  output  1  checker accepts the commit this cycle.
- commit_pc  input  64  PC of the committed instruction.
- commit_insn  input  32  encoding of the committed instruction.
- miss  output  1  reseed request to `iu` (level).
- pc_curr  output  64  reseed PC to `iu`.
- insn_curr  output  32  reseed instruction to `iu`.
- hit_cnt  output  CNT_W  number of correct predictions.
- miss_cnt  output  CNT_W  number of mispredictions.
- overflow  output  1  sticky: FIFO overflow has occurred.

Behaviour:
- Reset:
  - state=SEED; FIFO empty.
  - `miss`=0, `pc_curr`=0, `insn_curr`=0, `hit_cnt`=0, `miss_cnt`=0, `overflow`=0, last-commit register=0.
  - `commit_ready` is forced 0 while `rst`=1.
  - Reset asserted mid-operation aborts everything and returns to exactly this state.
- Handshake: a commit transfers when `commit_valid` and `commit_ready` are both high on a clock edge. `commit_valid` must hold its value until it transfers.
- State SEED:
  - `commit_ready`=1; FIFO pushes ignored.
  - On transfer: `pc_curr`<=`commit_pc`, `insn_curr`<=`commit_insn`, last-commit<=`commit_pc`, `miss`<=1, go to FLUSH. No counter changes.
- State FLUSH:
  - `miss`=1; `commit_ready`=0; FIFO held empty.
  - The first `pc_pre_oe` seen is discarded (stale path); go to RESEED.
- State RESEED (exactly 1 cycle):
  - `miss` stays 1 so `iu`, now in IDLE, samples `pc_curr`.
  - Next state RUN; `miss`<=0 on the transition to RUN.
  - A `pc_pre_oe` seen in this state is discarded.
- State RUN:
  - `pc_pre_oe` pushes `pc_pre` into the FIFO.
  - `commit_ready` = FIFO non-empty, from the registered count.
  - On transfer: pop head; last-commit<=`commit_pc`.
    - Head == `commit_pc` (all 64 bits): `hit_cnt`+1.
    - Otherwise: `miss_cnt`+1, flush FIFO, `pc_curr`<=`commit_pc`, `insn_curr`<=`commit_insn`, `miss`<=1, go to FLUSH.
- Push when FIFO is full with no pop in the same cycle:
  - Prediction is dropped; `overflow`<=1 (sticky until reset); FIFO flushed.
  - `pc_curr`<=last-commit; `insn_curr` is unchanged; `miss`<=1; go to FLUSH.
  - `miss_cnt` does not change.
- Push and pop in the same cycle:
  - Full FIFO: legal, no overflow, count unchanged.
  - Mismatch in the same cycle as a push: flush wins and the pushed entry is discarded.
- Counters wrap modulo 2^CNT_W.
- FIFO pointers wrap modulo DEPTH; occupancy uses a separate (log2 DEPTH)+1-bit count.
- Latency:
  - `miss` rises 1 cycle after the triggering transfer.
  - Compare result (counter update) is visible 1 cycle after transfer.
- All outputs are registered except `commit_ready`, which is a function of state and FIFO count.

Test Plan:
- Reset, commit 0x1000; `iu` running PC+4:
  - `miss`=1 and `pc_curr`=0x1000 one cycle later.
  - First `pc_pre_oe` discarded.
  - Commits 0x1004, 0x1008, 0x100C give `hit_cnt`=3, `miss_cnt`=0, `miss`=0 in RUN.
- After scenario 1, commit 0x2000 while head=0x1010:
  - `miss_cnt`=1, FIFO empty, `pc_curr`=0x2000.
  - Next commit 0x2004 gives `hit_cnt`=4.
- DEPTH=4, no commits while `iu` emits 5 predictions:
  - On the 5th, `overflow`=1 and `pc_curr`=last committed PC.
  - FIFO empty, FLUSH entered, `miss_cnt` unchanged.
- FIFO full with a commit transfer and `pc_pre_oe` in the same cycle (match): `hit_cnt`+1, count stays 4, `overflow`=0.
- `commit_valid` held high in RUN with an empty FIFO: `commit_ready`=0 and counters frozen until the next push, then the transfer completes one cycle later.
- `rst` pulsed during FLUSH:
  - All outputs 0 immediately (asynchronous).
  - After release, state is SEED with `commit_ready`=1.
